game_round_controller: RTL and testbench

- Sits directly downstream of the game-logic top. Consumes its collision flag (`pacman_is_dead`) and a per-frame tick.
- Sequences the round: idle → get-ready → play → death animation → respawn / game over.
- Tracks remaining lives. Drives the game-logic synchronous reset (`logic_rst`) and a `run` enable that gates sprite movement upstream.

---
 rtl/game_pkg.sv | 23 ++
 rtl/frame_down_counter.sv | 28 ++
 rtl/game_round_controller.sv | 120 ++++++++++++
 tb/tb_game_round_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game blocks: round-controller state codes,
// default round timing and the joystick/sprite direction codes.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READY     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_DYING     = 3'd3,
    ST_GAME_OVER = 3'd4
  } round_state_t;

  localparam int DEFAULT_DEATH_FRAMES = 60;
  localparam int DEFAULT_READY_FRAMES = 30;

  typedef enum logic [3:0] {
    RIGHT = 4'b0001,
    UP    = 4'b0010,
    DOWN  = 4'b0100,
    LEFT  = 4'b1000
  } dir_t;

endpackage

// File: rtl/frame_down_counter.sv
// Loadable frame-tick down counter; expire flags the tick that consumes the last frame.
module frame_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire = tick & (count == CNT_W'(1));

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer: idle, get-ready, play, death animation, respawn or game over.
// Tracks lives and drives the game-logic reset and the movement enable.
module game_round_controller
  import game_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int LIVES_W      = 2,
  parameter int DEATH_FRAMES = DEFAULT_DEATH_FRAMES,
  parameter int READY_FRAMES = DEFAULT_READY_FRAMES,
  parameter int FCNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               pacman_is_dead,
  output logic               logic_rst,
  output logic               run,
  output logic               dying,
  output logic               game_over,
  output logic [LIVES_W-1:0] lives,
  output logic [2:0]         state_out
);

  round_state_t       state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               start_q;
  logic               start_rise;

  logic               cnt_load;
  logic [FCNT_W-1:0]  cnt_load_val;
  logic               cnt_tick;
  logic [FCNT_W-1:0]  cnt_count;
  logic               cnt_expire;
  logic               cnt_done;

  assign start_rise = start_btn & ~start_q;

  // Only READY and DYING consume frames; other states leave the counter alone.
  assign cnt_tick = frame_tick & ((state_q == ST_READY) || (state_q == ST_DYING));
  // A zero count outside IDLE cannot be reached by loading; treat it as expiry.
  assign cnt_done = cnt_expire | (cnt_count == '0);

  frame_down_counter #(
    .CNT_W (FCNT_W)
  ) u_frame_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tick     (cnt_tick),
    .count    (cnt_count),
    .expire   (cnt_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lives_q <= LIVES_W'(LIVES_INIT);
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      start_q <= start_btn;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    cnt_load     = 1'b0;
    cnt_load_val = FCNT_W'(READY_FRAMES);

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_rise) begin
          lives_d  = LIVES_W'(LIVES_INIT);
          cnt_load = 1'b1;
          state_d  = ST_READY;
        end
      end
      ST_READY: begin
        if (cnt_done) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // Death takes priority over a coincident tick: the load discards it.
        if (pacman_is_dead) begin
          cnt_load     = 1'b1;
          cnt_load_val = FCNT_W'(DEATH_FRAMES);
          state_d      = ST_DYING;
        end
      end
      ST_DYING: begin
        if (cnt_done) begin
          if (lives_q <= LIVES_W'(1)) begin
            lives_d = '0;
            state_d = ST_GAME_OVER;
          end else begin
            lives_d  = lives_q - LIVES_W'(1);
            cnt_load = 1'b1;
            state_d  = ST_READY;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs, decoded from registered state only.
  assign logic_rst = (state_q == ST_IDLE) || (state_q == ST_READY) ||
                     (state_q == ST_GAME_OVER);
  assign run       = (state_q == ST_PLAY);
  assign dying     = (state_q == ST_DYING);
  assign game_over = (state_q == ST_GAME_OVER);
  assign lives     = lives_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Self-checking bench for game_round_controller: directed vector table,
// multi-cycle corner sequences, then random stimulus against a reference model.
module tb_game_round_controller;

  localparam int LI = 3;
  localparam int DF = 4;
  localparam int RF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       pacman_is_dead = 1'b0;
  logic       logic_rst, run, dying, game_over;
  logic [1:0] lives;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;

  game_round_controller #(
    .LIVES_INIT   (LI),
    .LIVES_W      (2),
    .DEATH_FRAMES (DF),
    .READY_FRAMES (RF),
    .FCNT_W       (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .start_btn      (start_btn),
    .pacman_is_dead (pacman_is_dead),
    .logic_rst      (logic_rst),
    .run            (run),
    .dying          (dying),
    .game_over      (game_over),
    .lives          (lives),
    .state_out      (state_out)
  );

  always #5 clk = ~clk;

  // Expected output word {state, lives, logic_rst, run, dying, game_over}.
  function automatic logic [8:0] pack_exp(input int st, input int lv);
    logic lr, rn, dy, go;
    lr = (st == 0) || (st == 1) || (st == 4);
    rn = (st == 2);
    dy = (st == 3);
    go = (st == 4);
    return {3'(st), 2'(lv), lr, rn, dy, go};
  endfunction

  function automatic logic [8:0] act_word();
    return {state_out, lives, logic_rst, run, dying, game_over};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d lives=%0d flags(lr,run,dy,go)=%b, expected state=%0d lives=%0d flags=%b",
               name, act[8:6], act[5:4], act[3:0], exp[8:6], exp[5:4], exp[3:0]);
    end
  endtask

  task automatic expect_st(input string name, input int st, input int lv);
    check(name, act_word(), pack_exp(st, lv));
  endtask

  // Apply one cycle of inputs, then sample just after the edge.
  task automatic step(input logic r, input logic t, input logic s, input logic d);
    rst            = r;
    frame_tick     = t;
    start_btn      = s;
    pacman_is_dead = d;
    @(posedge clk);
    #1;
  endtask

  // Reference model: round phase, frames remaining in the current phase, lives.
  int m_state, m_lives, m_left;
  bit m_prev_start;

  function automatic void model_step(input bit r, input bit t, input bit s, input bit d);
    bit rise;
    rise = s && !m_prev_start;
    m_prev_start = r ? 1'b0 : s;
    if (r) begin
      m_state = 0; m_lives = LI; m_left = 0;
      return;
    end
    case (m_state)
      0, 4: if (rise) begin m_lives = LI; m_left = RF; m_state = 1; end
      1: if (t) begin
           m_left = m_left - 1;
           if (m_left == 0) m_state = 2;
         end
      2: if (d) begin m_left = DF; m_state = 3; end
      3: if (t) begin
           m_left = m_left - 1;
           if (m_left == 0) begin
             m_lives = m_lives - 1;
             if (m_lives == 0) m_state = 4;
             else begin m_left = RF; m_state = 1; end
           end
         end
      default: m_state = 0;
    endcase
  endfunction

  typedef struct {
    logic r, t, s, d;
    int   st, lv;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic r, t, d, s_lvl;

    // rst, tick, start, dead -> state, lives after the edge
    vecs[0]  = '{1, 0, 0, 0, 0, 3};  // reset
    vecs[1]  = '{0, 0, 1, 0, 1, 3};  // start press
    vecs[2]  = '{0, 0, 0, 0, 1, 3};
    vecs[3]  = '{0, 1, 0, 0, 1, 3};  // 2 -> 1
    vecs[4]  = '{0, 0, 0, 1, 1, 3};  // death ignored in READY
    vecs[5]  = '{0, 1, 0, 0, 2, 3};  // expiry -> PLAY
    vecs[6]  = '{0, 1, 0, 0, 2, 3};  // tick in PLAY does nothing
    vecs[7]  = '{0, 0, 1, 0, 2, 3};  // start in PLAY ignored
    vecs[8]  = '{0, 0, 0, 1, 3, 3};  // death
    vecs[9]  = '{0, 1, 0, 1, 3, 3};  // 4 -> 3, flag ignored
    vecs[10] = '{0, 1, 0, 0, 3, 3};  // 3 -> 2
    vecs[11] = '{0, 1, 0, 0, 3, 3};  // 2 -> 1
    vecs[12] = '{0, 0, 1, 0, 3, 3};  // start in DYING ignored
    vecs[13] = '{0, 1, 1, 0, 1, 2};  // expiry -> READY, lives 2
    vecs[14] = '{0, 1, 0, 0, 1, 2};
    vecs[15] = '{0, 1, 0, 0, 2, 2};  // back in PLAY

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].r, vecs[i].t, vecs[i].s, vecs[i].d);
      check($sformatf("vec%0d", i), act_word(), pack_exp(vecs[i].st, vecs[i].lv));
    end

    // Tick and death together: the tick is not counted, so four more ticks are needed.
    step(0, 1, 0, 1); expect_st("simul_enter_dying", 3, 2);
    repeat (3) step(0, 1, 0, 0);
    expect_st("simul_after_3_ticks", 3, 2);
    step(0, 1, 0, 0); expect_st("simul_exit_ready", 1, 1);

    // Last life: death flag held through DYING, start held across game-over entry.
    repeat (2) step(0, 1, 0, 0);
    expect_st("last_life_play", 2, 1);
    step(0, 0, 0, 1); expect_st("last_life_dying", 3, 1);
    repeat (3) step(0, 1, 1, 1);
    expect_st("dying_ignores_start", 3, 1);
    step(0, 1, 1, 1); expect_st("game_over_entry", 4, 0);
    repeat (3) step(0, 0, 1, 0);
    expect_st("held_start_no_restart", 4, 0);
    step(0, 0, 0, 0); expect_st("game_over_idle", 4, 0);
    step(0, 0, 1, 0); expect_st("restart_ready", 1, 3);

    // Reset in DYING with two frames left and two lives.
    repeat (2) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    repeat (4) step(0, 1, 0, 0);
    expect_st("rst_seq_ready_lives2", 1, 2);
    repeat (2) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    repeat (2) step(0, 1, 0, 0);
    expect_st("rst_seq_dying_cnt2", 3, 2);
    step(1, 0, 0, 0); expect_st("rst_mid_dying", 0, 3);

    // Random stimulus against the reference model.
    s_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r = (i == 0) || ($urandom_range(0, 299) == 0);
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 11) == 0) s_lvl = ~s_lvl;
      d = ($urandom_range(0, 9) == 0);
      model_step(r, t, s_lvl, d);
      step(r, t, s_lvl, d);
      check($sformatf("random%0d", i), act_word(), pack_exp(m_state, m_lives));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
